// File: rtl/seq_pkg.sv
// seq_pkg: shared operation encoding for the program sequencer.
package seq_pkg;

    // Two-bit op select presented on program_sequencer.op
    localparam logic [1:0] OP_NEXT   = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_CALL   = 2'b10;
    localparam logic [1:0] OP_RETURN = 2'b11;

endpackage : seq_pkg

// File: rtl/program_sequencer_return_stack.sv
// return_stack: LIFO of return addresses for the program sequencer.
// A push while full and a pop while empty are ignored. dout shows the current
// top entry combinationally. Entry storage is never cleared; reset only
// rewinds the entry count.
module return_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             wr_en;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    top_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign top_idx = IW'(count_q - CW'(1));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign dout    = mem[top_idx];

    // Next count and write port; simultaneous push/pop replaces the top entry
    always_comb begin
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = IW'(count_q);
        if (do_push && do_pop) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (do_push) begin
            wr_en   = 1'b1;
            wr_idx  = IW'(count_q);
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Entry count register, rewound by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= din;
        end
    end

endmodule : return_stack

// File: rtl/program_sequencer.sv
// program_sequencer: program counter with NEXT/BRANCH/CALL/RETURN and a
// return-address stack. Sticky overflow/underflow flags clear only on reset.
// Build option: define BRANCH_REL_EN to make BRANCH/CALL targets relative
// (addr_out + signed branch_addr); otherwise targets are absolute.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [1:0]                       op,
    input  logic [ADDR_W-1:0]                branch_addr,
    input  logic                             stall,
    output logic [ADDR_W-1:0]                addr_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              overflow_q;
    logic              overflow_d;
    logic              underflow_q;
    logic              underflow_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_dout;
    logic [DW-1:0]     stk_count;
    logic              stk_full;
    logic              stk_empty;

    // Wraps naturally at 2^ADDR_W; also the return address for CALL
    assign pc_inc = addr_q + ADDR_W'(1);

`ifdef BRANCH_REL_EN
    // Modular add is identical to adding a two's-complement signed offset
    assign target = addr_q + branch_addr;
`else
    assign target = branch_addr;
`endif

    // Next program counter, flag updates and stack commands for this cycle
    always_comb begin
        addr_d      = addr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        if (!stall) begin
            case (op)
                OP_NEXT: begin
                    addr_d = pc_inc;
                end
                OP_BRANCH: begin
                    addr_d = target;
                end
                OP_CALL: begin
                    addr_d = target;
                    if (stk_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        stk_push = 1'b1;
                    end
                end
                OP_RETURN: begin
                    if (stk_empty) begin
                        addr_d      = pc_inc;
                        underflow_d = 1'b1;
                    end else begin
                        addr_d  = stk_dout;
                        stk_pop = 1'b1;
                    end
                end
                default: begin
                    addr_d = addr_q;
                end
            endcase
        end
    end

    // Program counter and sticky flags; reset overrides stall and op
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= RESET_ADDR;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    return_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .count (stk_count),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign addr_out    = addr_q;
    assign stack_depth = stk_count;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule : program_sequencer

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed plus random stimulus against a queue-based
// reference model; expected states are queued at drive time and compared by
// an independent monitor after each rising edge.
module tb_program_sequencer;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic [1:0]        op;
    logic [ADDR_W-1:0] branch_addr;
    logic              stall;
    logic [ADDR_W-1:0] addr_out;
    logic [2:0]        stack_depth;
    logic              overflow;
    logic              underflow;

    program_sequencer #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .branch_addr (branch_addr),
        .stall       (stall),
        .addr_out    (addr_out),
        .stack_depth (stack_depth),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          depth;
        logic        ovf;
        logic        unf;
        int          txn;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          txn_n  = 0;

    // Reference model state: plain PC plus a queue used as a LIFO
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_ovf;
    logic        m_unf;

    function automatic logic [15:0] m_target(input logic [15:0] pc, input logic [15:0] b);
`ifdef BRANCH_REL_EN
        return pc + b;
`else
        return b;
`endif
    endfunction

    task automatic step(input logic [1:0] o, input logic [15:0] b, input logic s, input logic r);
        exp_t e;
        @(negedge clk);
        op          = o;
        branch_addr = b;
        stall       = s;
        reset       = r;
        if (r) begin
            m_pc  = 16'h0000;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!s) begin
            case (o)
                2'b00: m_pc = m_pc + 16'd1;
                2'b01: m_pc = m_target(m_pc, b);
                2'b10: begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 16'd1);
                    else m_ovf = 1'b1;
                    m_pc = m_target(m_pc, b);
                end
                default: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin
                        m_pc  = m_pc + 16'd1;
                        m_unf = 1'b1;
                    end
                end
            endcase
        end
        txn_n++;
        e.addr = m_pc; e.depth = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf; e.txn = txn_n;
        exp_q.push_back(e);
    endtask

    // Monitor: one observed state per rising edge, compared against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 4;
                if (addr_out !== e.addr) begin
                    errors++;
                    $display("FAIL addr_out txn %0d: got %h expected %h", e.txn, addr_out, e.addr);
                end
                if (stack_depth !== 3'(e.depth)) begin
                    errors++;
                    $display("FAIL stack_depth txn %0d: got %0d expected %0d", e.txn, stack_depth, e.depth);
                end
                if (overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL overflow txn %0d: got %b expected %b", e.txn, overflow, e.ovf);
                end
                if (underflow !== e.unf) begin
                    errors++;
                    $display("FAIL underflow txn %0d: got %b expected %b", e.txn, underflow, e.unf);
                end
                $display("txn %0d op=%0d stall=%b reset=%b addr=%h depth=%0d ovf=%b unf=%b",
                         e.txn, op, stall, reset, addr_out, stack_depth, overflow, underflow);
            end
        end
    end

    initial begin
        exp_t e0;
        int   k;
        int   r;
        // First edge applies reset
        op = 2'b00; branch_addr = '0; stall = 1'b0; reset = 1'b1;
        m_pc = 16'h0000; m_ovf = 1'b0; m_unf = 1'b0;
        e0.addr = 16'h0000; e0.depth = 0; e0.ovf = 1'b0; e0.unf = 1'b0; e0.txn = 0;
        exp_q.push_back(e0);

        // Five NEXTs count up from zero
        for (int i = 0; i < 5; i++) step(2'b00, 16'h0, 1'b0, 1'b0);
        // CALL from 0x0010, run three NEXTs, return to 0x0011
        step(2'b01, 16'h0010, 1'b0, 1'b0);
        step(2'b10, 16'h1388, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b00, 16'h0, 1'b0, 1'b0);
        step(2'b11, 16'h0, 1'b0, 1'b0);
        // Nested calls beyond capacity, then over-return
        step(2'b00, 16'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) step(2'b10, 16'(i * 16'h0100), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(2'b11, 16'h0, 1'b0, 1'b0);
        // Wrap at all-ones, then stall with CALL pending
        step(2'b01, 16'hFFFF, 1'b0, 1'b0);
        step(2'b00, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b10, 16'h2222, 1'b1, 1'b0);
        // Depth 3 with both flags set, then reset with CALL and stall asserted
        for (int i = 0; i < 5; i++) step(2'b10, 16'h0040, 1'b0, 1'b0);
        step(2'b11, 16'h0, 1'b0, 1'b0);
        step(2'b00, 16'h0, 1'b0, 1'b1);
        step(2'b11, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b10, 16'(16'h0300 + i), 1'b0, 1'b0);
        step(2'b10, 16'h0777, 1'b1, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            k = $urandom_range(0, 3);
            step(2'(k), 16'($urandom), (r < 15), (r > 97));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_program_sequencer
